// File: rtl/vga_scanout_if.sv
// Framebuffer read bus between the scanout engine and the framebuffer RAM.
//   fb_addr   : read address, 160x120 row-major (0..19199)
//   fb_rd_en  : read strobe, high only for visible-area addresses
//   fb_data   : read data {R,G,B} 4 bits each, valid one clock after the address
// master = scanout engine, slave = framebuffer memory.
interface vga_scanout_if;
    logic [14:0] fb_addr;
    logic        fb_rd_en;
    logic [11:0] fb_data;

    modport master (output fb_addr, output fb_rd_en, input fb_data);
    modport slave  (input fb_addr, input fb_rd_en, output fb_data);
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout engine: free-running h/v counters, 4x4 upscaled framebuffer
// fetch and a three-stage pipeline that keeps colour and syncs aligned.
// Ports:
//   clk            pixel clock, rising edge
//   rst_n          asynchronous active-low reset
//   fb             framebuffer read bus (master side)
//   vga_r/g/b_o    registered pixel colour, 0 outside the visible area
//   hsync_o/vsync_o registered syncs, active low, 3 clocks after counter state
//   vblank_o       vertical counter in blanking, 1 clock after counter state
//   frame_start_o  one-clock pulse for counter state (0,0), 1 clock latency
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_scanout_if.master     fb,
    output logic [3:0]        vga_r_o,
    output logic [3:0]        vga_g_o,
    output logic [3:0]        vga_b_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              vblank_o,
    output logic              frame_start_o
);

    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;

    logic        vis;
    logic        hs_n, vs_n;
    logic [7:0]  fx, fy;
    logic [14:0] addr_calc;

    // stage 1: address fetch, stage 2: aligned with RAM output, stage 3: pins
    logic [14:0] fb_addr_q;
    logic        rd_en_q;
    logic        hs1_q, vs1_q;
    logic        vis2_q, hs2_q, vs2_q;
    logic [11:0] rgb3_q;
    logic        hs3_q, vs3_q;
    logic        vblank_q, frame_start_q;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    assign vis  = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    assign hs_n = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    assign vs_n = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

    // fy*160 + fx as two shifts and adds; fy<=119, fx<=159 keeps it <=19199
    assign fx        = h_cnt_q[9:2];
    assign fy        = v_cnt_q[9:2];
    assign addr_calc = {fy, 7'b0} + {2'b0, fy, 5'b0} + {7'b0, fx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            fb_addr_q     <= 15'd0;
            rd_en_q       <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            vis2_q        <= 1'b0;
            hs2_q         <= 1'b1;
            vs2_q         <= 1'b1;
            rgb3_q        <= 12'd0;
            hs3_q         <= 1'b1;
            vs3_q         <= 1'b1;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            // address holds outside the visible area so the RAM input stays quiet
            if (vis) begin
                fb_addr_q <= addr_calc;
            end
            rd_en_q       <= vis;
            hs1_q         <= hs_n;
            vs1_q         <= vs_n;
            vis2_q        <= rd_en_q;
            hs2_q         <= hs1_q;
            vs2_q         <= vs1_q;
            // fb_data is only trusted in the cycle after a read strobe
            rgb3_q        <= vis2_q ? fb.fb_data : 12'd0;
            hs3_q         <= hs2_q;
            vs3_q         <= vs2_q;
            vblank_q      <= (v_cnt_q >= V_VIS_C);
            frame_start_q <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        end
    end

    assign fb.fb_addr    = fb_addr_q;
    assign fb.fb_rd_en   = rd_en_q;
    assign vga_r_o       = rgb3_q[11:8];
    assign vga_g_o       = rgb3_q[7:4];
    assign vga_b_o       = rgb3_q[3:0];
    assign hsync_o       = hs3_q;
    assign vsync_o       = vs3_q;
    assign vblank_o      = vblank_q;
    assign frame_start_o = frame_start_q;

endmodule
